// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use a shift-add over W cycles, DIV/DIVU a restoring divide
// over W cycles, both on operand magnitudes, followed by one sign-fix
// cycle that writes HI/LO. MTHI/MTLO write HI/LO directly while idle.
module mult_div_unit #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start_in,
  input  logic [2:0]   op_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy_out,
  output logic         done_out,
  output logic         div_zero_out,
  output logic [W-1:0] hi_out,
  output logic [W-1:0] lo_out
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // Two's complement negation of a W-bit value.
  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
    logic signed [W-1:0] s;
    s = $signed(v);
    return -s;
  endfunction

  // Two's complement negation of the 2W-bit product.
  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
    logic signed [2*W-1:0] s;
    s = $signed(v);
    return -s;
  endfunction

  // Magnitude of an operand; only negated when it is a negative signed operand.
  function automatic logic [W-1:0] mag_w(input logic [W-1:0] v, input logic neg);
    return neg ? neg_w(v) : v;
  endfunction

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] prod;     // mult: {acc_hi, multiplier}; div: {rem, quo}
  logic [W-1:0]   opnd;     // mult: multiplicand magnitude; div: divisor magnitude
  logic [W-1:0]   a_orig;   // dividend as issued, returned in HI on divide by zero
  logic           sign_a;
  logic           sign_b;
  logic           is_div;
  logic           b_zero;

  logic           op_signed;
  logic           start_sa;
  logic           start_sb;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_trial;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod_fixed;

  assign busy_out = (state != S_IDLE);

  // Sign capture for a newly issued command and one iteration of each algorithm.
  always_comb begin
    op_signed  = (op_in == OP_MULT) || (op_in == OP_DIV);
    start_sa   = op_signed & a_in[W-1];
    start_sb   = op_signed & b_in[W-1];

    mul_sum    = {1'b0, prod[2*W-1:W]} + {1'b0, opnd};
    mul_next   = prod[0] ? {mul_sum, prod[W-1:1]} : {1'b0, prod[2*W-1:1]};

    // Bit W of the trial result set means the subtraction underflowed.
    div_trial  = {prod[2*W-1:W], prod[W-1]} - {1'b0, opnd};
    div_next   = div_trial[W] ? {prod[2*W-2:0], 1'b0}
                              : {div_trial[W-1:0], prod[W-2:0], 1'b1};

    prod_fixed = (sign_a ^ sign_b) ? neg_2w(prod) : prod;
  end

  // Control: state sequencing, iteration counter and completion pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      done_out     <= 1'b0;
      div_zero_out <= 1'b0;
    end else begin
      done_out     <= 1'b0;
      div_zero_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_in) begin
            cnt <= '0;
            if ((op_in == OP_MULT) || (op_in == OP_MULTU)) state <= S_MUL;
            else if ((op_in == OP_DIV) || (op_in == OP_DIVU)) state <= S_DIV;
          end
        end
        S_MUL, S_DIV: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= S_FIX;
        end
        default: begin
          done_out     <= 1'b1;
          div_zero_out <= is_div & b_zero;
          state        <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: operand capture, iteration registers and HI/LO write-back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prod   <= '0;
      opnd   <= '0;
      a_orig <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      is_div <= 1'b0;
      b_zero <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_in) begin
            case (op_in)
              OP_MTHI: hi_out <= a_in;
              OP_MTLO: lo_out <= a_in;
              OP_MULT, OP_MULTU: begin
                prod   <= {{W{1'b0}}, mag_w(b_in, start_sb)};
                opnd   <= mag_w(a_in, start_sa);
                sign_a <= start_sa;
                sign_b <= start_sb;
                is_div <= 1'b0;
                b_zero <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                prod   <= {{W{1'b0}}, mag_w(a_in, start_sa)};
                opnd   <= mag_w(b_in, start_sb);
                a_orig <= a_in;
                sign_a <= start_sa;
                sign_b <= start_sb;
                is_div <= 1'b1;
                b_zero <= (b_in == '0);
              end
              default: ;
            endcase
          end
        end
        S_MUL: prod <= mul_next;
        S_DIV: prod <= div_next;
        default: begin
          if (!is_div) begin
            hi_out <= prod_fixed[2*W-1:W];
            lo_out <= prod_fixed[W-1:0];
          end else if (b_zero) begin
            hi_out <= a_orig;
            lo_out <= '1;
          end else begin
            lo_out <= (sign_a ^ sign_b) ? neg_w(prod[W-1:0]) : prod[W-1:0];
            hi_out <= sign_a ? neg_w(prod[2*W-1:W]) : prod[2*W-1:W];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (W=32): mult/div results, latency,
// done/div-zero pulses, MT writes, ignored commands and async reset.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic         clock;
  logic         reset;
  logic         start_in;
  logic [2:0]   op_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy_out;
  logic         done_out;
  logic         div_zero_out;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int n_checks;
  int n_errors;

  mult_div_unit #(.W(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start_in     (start_in),
    .op_in        (op_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .div_zero_out (div_zero_out),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present a command for exactly one rising edge; returns at the negedge after it.
  task automatic start_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start_in = 1'b1;
    op_in    = op;
    a_in     = a;
    b_in     = b;
    @(negedge clock);
    start_in = 1'b0;
  endtask

  // Sample at negedges until done_out, counting busy cycles seen on the way.
  task automatic wait_done(input string tag, output int nbusy);
    int n;
    n     = 0;
    nbusy = 0;
    while (!done_out && n < 100) begin
      if (busy_out) nbusy++;
      n++;
      @(negedge clock);
    end
    if (!done_out) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input logic exp_dz);
    int nb;
    start_cmd(op, a, b);
    wait_done(tag, nb);
    check({tag, "_busycycles"}, 64'(nb), 64'(W + 1));
    check({tag, "_busy_at_done"}, 64'(busy_out), 64'd0);
    check({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
    check({tag, "_dz"}, 64'(div_zero_out), 64'(exp_dz));
    @(negedge clock);
    check({tag, "_done_pulse"}, 64'(done_out), 64'd0);
    check({tag, "_dz_pulse"}, 64'(div_zero_out), 64'd0);
  endtask

  initial begin
    int nb;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    start_in = 1'b0;
    op_in    = '0;
    a_in     = '0;
    b_in     = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_done", 64'(done_out), 64'd0);
    check("rst_dz", 64'(div_zero_out), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);

    run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_m1xm1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
    run_op("div_m7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7bym2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7by2", OP_DIVU, 32'd7, 32'd2, 32'h1, 32'h3, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 32'h7, 32'hFFFF_FFFF, 1'b1);
    run_op("div_neg_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

    // MTHI while idle: visible after one edge, never busy.
    @(negedge clock);
    start_in = 1'b1;
    op_in    = OP_MTHI;
    a_in     = 32'h1234_5678;
    @(posedge clock);
    #1;
    check("mthi_hi", 64'(hi_out), 64'h1234_5678);
    check("mthi_busy", 64'(busy_out), 64'd0);
    @(negedge clock);
    start_in = 1'b0;
    check("mthi_done", 64'(done_out), 64'd0);

    // No-op code: nothing changes.
    start_cmd(OP_NOP, 32'hAAAA_AAAA, 32'h5555_5555);
    check("nop_busy", 64'(busy_out), 64'd0);
    check("nop_hi", 64'(hi_out), 64'h1234_5678);
    check("nop_lo", 64'(lo_out), 64'hFFFF_FFFF);

    // MTLO issued mid-MULT is ignored.
    start_cmd(OP_MULT, 32'd6, 32'd7);
    repeat (3) @(negedge clock);
    start_in = 1'b1;
    op_in    = OP_MTLO;
    a_in     = 32'hDEAD_BEEF;
    @(negedge clock);
    start_in = 1'b0;
    wait_done("mult_mtlo", nb);
    check("mult_mtlo_lo", 64'(lo_out), 64'd42);
    check("mult_mtlo_hi", 64'(hi_out), 64'd0);
    @(negedge clock);

    // Async reset mid-DIVU: outputs clear immediately, no done afterwards.
    start_cmd(OP_DIVU, 32'd100, 32'd3);
    repeat (9) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy_out), 64'd0);
    check("arst_hi", 64'(hi_out), 64'd0);
    check("arst_lo", 64'(lo_out), 64'd0);
    check("arst_done", 64'(done_out), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done_out || busy_out) nb++;
    end
    check("arst_no_done", 64'(nb), 64'd0);

    run_op("multu_3x4", OP_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It sits beside the ALU in the datapath and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO over multiple cycles. It drives a busy signal that control uses to deassert the PC enable. MFHI/MFLO read `hi_out`/`lo_out` directly through the write-back mux.

## Interface
- `W`, default 32: operand, HI and LO width; must be ≥ 2.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start_in` in 1: command strobe, sampled on the rising edge.
- `op_in` in 3: operation code.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- `a_in` in W: rs operand (multiplicand / dividend / MT source).
- `b_in` in W: rt operand (multiplier / divisor).
- `busy_out` out 1: an operation is in flight; control stalls the PC.
- `done_out` out 1: one-cycle pulse when HI/LO take a mult/div result.
- `div_zero_out` out 1: high together with `done_out` when the completed divide had `b_in`=0.
- `hi_out` out W: HI register (product upper half / remainder).
- `lo_out` out W: LO register (product lower half / quotient).

## Operation
- States: IDLE, MUL, DIV, FIX.
- **IDLE**, `start_in`=1:
  - MTHI / MTLO: write `a_in` to HI / LO at that edge; stay in IDLE; no busy, no done.
  - MULT / MULTU / DIV / DIVU: latch the operands, record both sign bits (signed ops only; zero for unsigned), convert operands to magnitudes, clear the iteration counter, and go to MUL or DIV.
  - Codes 110 and 111: ignored.
- **MUL**: shift-add on a 2W-bit accumulator, one multiplier bit per cycle, LSB first. W iterations, then FIX.
- **DIV**: restoring division on magnitudes.
  - Each cycle: shift {rem, quo} left by 1; trial-subtract the divisor from rem; keep the result and set the quotient bit if it does not underflow.
  - W iterations, then FIX.
- **FIX**: one cycle; writes HI/LO and pulses `done_out`; always returns to IDLE.
  - Multiply: if the operand signs differ, negate the 2W-bit product (two's complement). HI = upper W bits, LO = lower W bits.
  - Divide: LO = quotient, negated if the operand signs differ. HI = remainder, negated if the dividend is negative.
  - Divide by zero: skip sign fix-up. HI = original `a_in`, LO = all ones, `div_zero_out`=1.
  - Signed overflow case −2^(W−1) / −1: LO = 0x80…0, HI = 0. This falls out of the magnitude arithmetic; no flag is raised.
- `start_in` while not IDLE is ignored, including MTHI/MTLO. Control must not issue commands while busy.
- HI/LO change only on an MT write, in FIX, or on reset.

## Timing
- Reset values: state IDLE; `busy_out`=0, `done_out`=0, `div_zero_out`=0, `hi_out`=0, `lo_out`=0; counter and accumulators 0.
- Let start be accepted at edge T0.
  - `busy_out`=1 from after T0 through the cycle ending at edge T0+W+1, which is the FIX edge.
  - HI/LO carry the result after edge T0+W+1.
  - `done_out` and `div_zero_out` are high for exactly the one cycle after edge T0+W+1.
  - `busy_out` is 0 in that same cycle.
- Total latency is W+1 cycles (33 for W=32). Latency is identical for all four mult/div ops, including divide by zero.
- A new start may be accepted on the edge that ends the `done_out` cycle. Back-to-back operations have no dead cycle beyond FIX.
- MTHI/MTLO latency: 1 edge; the value is visible after that edge.
- Counter width: $clog2(W+1).
- Reset asserted mid-operation: immediate return to reset values. The partial result is discarded, and no `done_out` is generated.

## Test plan
- MULT, a=0xFFFFFFFD (−3), b=5 → after 33 cycles: HI=0xFFFFFFFF, LO=0xFFFFFFF1; `done_out` pulses once; `busy_out` high for exactly 33 cycles.
- MULTU, a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT with the same operands → HI=0, LO=1.
- DIV, a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, a=7, b=2 → LO=3, HI=1.
- DIV, a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU, a=7, b=0 → HI=7, LO=0xFFFFFFFF; `div_zero_out` and `done_out` both high for one cycle.
- MTHI a=0x12345678 while idle → `hi_out`=0x12345678 after one edge; `busy_out` stays 0. Then start MULT and pulse MTLO at cycle 5 → MTLO ignored; LO holds the product.
- Start DIVU; assert `reset` asynchronously at cycle 10 mid-cycle → all outputs 0 immediately. After release, a fresh MULTU 3×4 → LO=12, HI=0 at 33 cycles.
